ic_74194_param: RTL

Parametrised universal shift register: the next generation of our dual D flip-flop parts, generalised from single bits to a WIDTH-bit register. Each edge performs one of four modes: hold, shift right, shift left, or parallel load. It adds features the fixed-width 74194 lacks: a clock enable, a rotate option and a programmable reset value. It is a drop-in storage/shift element for the chips library and the benches built on it.

---
 rtl/ic_74194_param.sv | 78 +++++++
 1 files changed

// File: rtl/ic_74194_param.sv
// Parametrised universal shift register: hold, shift right (toward MSB), shift left
// (toward LSB) or parallel load on each enabled rising edge, with rotate and reset value.
module ic_74194_param #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             CP,
  input  logic             RD,
  input  logic             CE,
  input  logic [1:0]       S,
  input  logic             ROT,
  input  logic             DSR,
  input  logic             DSL,
  input  logic [WIDTH-1:0] P,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] nQ
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  mode_e            mode;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] shr_val;
  logic [WIDTH-1:0] shl_val;
  logic             shr_in;
  logic             shl_in;

  assign mode = mode_e'(S);

  // With ROT set the bit falling off one end re-enters at the other end.
  always_comb begin
    shr_in = ROT ? q_q[WIDTH-1] : DSR;
    shl_in = ROT ? q_q[0]       : DSL;
  end

  // A one-bit register has no neighbours, so a shift simply loads the entering bit.
  generate
    if (WIDTH == 1) begin : g_w1
      assign shr_val = shr_in;
      assign shl_val = shl_in;
    end else begin : g_wn
      assign shr_val = {q_q[WIDTH-2:0], shr_in};
      assign shl_val = {shl_in, q_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    q_d = q_q;
    if (CE) begin
      case (mode)
        MODE_HOLD: q_d = q_q;
        MODE_SHR:  q_d = shr_val;
        MODE_SHL:  q_d = shl_val;
        MODE_LOAD: q_d = P;
        default:   q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge CP or posedge RD) begin
    if (RD) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  // nQ is always derived from the single stored copy of Q.
  assign Q  = q_q;
  assign nQ = ~q_q;

endmodule
